// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding,
// register-file constants and the opcodes decoded by the control unit.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

endpackage

// File: rtl/pipeline_hazard_ctrl_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-cycle advance/hold/bubble decisions for the 5-stage MIPS pipeline,
// with a memory-wait watchdog and stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    hz_state_t         state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_timeout_reg, mem_timeout_next;

    logic mem_wait;
    logic load_use;
    logic flush_evt;

    assign mem_wait = mem_req && !mem_ready;
    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Priority: reset, freeze (wait or error), taken branch, load-use, jump.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        flush_evt    = 1'b0;
        if (RST) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if ((state_reg == ERR) || mem_wait) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
            flush_evt  = 1'b1;
        end
    end

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_timeout_next = mem_timeout_reg;
        case (state_reg)
            RUN: begin
                if (mem_wait) begin
                    state_next    = MEMWAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEMWAIT: begin
                if (!mem_wait) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_W'(MAX_WAIT)) begin
                    state_next       = ERR;
                    mem_timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    assign mem_timeout = mem_timeout_reg;

    // Index 0 counts stall cycles, index 1 counts flush events.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = !RST && !pc_write;
    assign cnt_inc[1] = !RST && flush_evt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            hazard_sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (CLK),
                .srst  (RST),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_count = cnt_val[0];
    assign flush_count = cnt_val[1];

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage MIPS pipeline. It decides each cycle whether every pipeline register advances, holds or is bubbled.
- Detects load-use hazards (ID vs EX).
- Flushes the wrong path on a taken branch (resolved in EX) or a jump (decoded in ID).
- Freezes the whole pipeline while the data-memory port is not ready, with a timeout watchdog.
- Sits beside the control unit and drives the write-enable and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- MAX_WAIT, 16, maximum consecutive memory-wait cycles before timeout error.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- id_jump  in  1  Jump control bit of the instruction in ID (j/jal)
- ex_rt  in  5  destination rt of the instruction in EX
- ex_mem_read  in  1  MemRead of the instruction in EX
- ex_branch_taken  in  1  Branch AND zero, resolved in EX
- mem_req  in  1  MEM stage performs a load/store this cycle
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_write  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX clear (all control bits 0)
- exmem_write  out  1  EX/MEM load enable
- memwb_bubble  out  1  MEM/WB loads a NOP (RegWrite=0)
- mem_timeout  out  1  sticky error flag
- stall_count  out  CNT_W  cycles with pc_write=0 (excluding reset)
- flush_count  out  CNT_W  number of flush events

Behaviour:
- FSM states: RUN, MEMWAIT, ERR. Registered state; wait_cnt register (width clog2(MAX_WAIT+1)).
- Control outputs are combinational from state and inputs. Hazards act in the same cycle they are detected.
- RST=1 forces the following, and on that edge sets state=RUN, wait_cnt=0, counters=0, mem_timeout=0:
  - pc_write=0, ifid_write=0, idex_write=0, exmem_write=0
  - ifid_flush=1, idex_flush=1, memwb_bubble=1
- Default in RUN with no hazard: all *_write=1, all flushes/bubble=0.
- Priority, highest first:
  1. Memory wait: mem_req && !mem_ready.
     - pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1.
     - Branch, jump and load-use are ignored this cycle and re-evaluated once the freeze ends.
  2. Taken branch: ex_branch_taken.
     - ifid_flush=1, idex_flush=1; pc_write=1 (PC loads the target).
     - flush_count+1.
  3. Load-use: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
     - pc_write=0, ifid_write=0, idex_flush=1.
     - Exactly one bubble; the next cycle sees the load in MEM and no match.
  4. Jump: id_jump.
     - ifid_flush=1, flush_count+1.
  - A jump and a load-use in the same cycle: the load-use stall wins and the jump is re-presented next cycle.
- Transitions:
  - RUN -> MEMWAIT when memory wait is detected; wait_cnt=1.
  - MEMWAIT stays while the wait persists; wait_cnt+1.
  - MEMWAIT -> RUN on mem_ready (that cycle advances normally, per the priority list); wait_cnt=0.
  - MEMWAIT -> ERR when wait_cnt==MAX_WAIT and still waiting; mem_timeout=1.
- ERR: full freeze (same outputs as memory wait) until RST. mem_timeout stays 1.
- Counters:
  - stall_count increments in every non-reset cycle with pc_write=0, including ERR.
  - Both counters saturate at 2^CW-1; no wrap.
- Reset mid-MEMWAIT or in ERR: returns to RUN on the next edge, with no residual stall.

Decomposition:
- Shared package: state encoding (RUN=2'd0, MEMWAIT=2'd1, ERR=2'd2), a REG_ZERO constant, and the opcode constants already used by the control unit (R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011).
- One natural sub-module: hazard_sat_counter (CNT_W-bit saturating counter with sync reset and inc enable), instantiated twice.

Test Plan:
- Reset: RST=1 for 2 cycles, then released with no hazards → pc_write=1, all flushes 0, stall_count=0, flush_count=0.
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 → pc_write=0, ifid_write=0, idex_flush=1 for exactly 1 cycle; stall_count=1. Repeat with ex_rt=0 → no stall.
- Branch: ex_branch_taken=1 in the same cycle as id_jump=1 → ifid_flush=1, idex_flush=1, pc_write=1; flush_count increments by exactly 1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 with ex_branch_taken=1 held throughout → 3 frozen cycles with memwb_bubble=1, then the flush occurs in the ready cycle; stall_count=3.
- Timeout: MAX_WAIT=4, mem_ready held 0 → mem_timeout=1 after 5th wait edge, freeze persists; RST=1 clears mem_timeout and returns to RUN.
- Saturation: CNT_W=3, 10 load-use stalls → stall_count=7.
